// File: rtl/terrain_pkg.sv
// Shared constants, types and the code-to-height mapping for the scrolling terrain.
package terrain_pkg;

   localparam int SEG_W     = 16;
   localparam int BUF_DEPTH = 64;
   localparam int GEN_AHEAD = 41;
   localparam int STICK_X   = 160;
   localparam int PIT_Y     = 480;
   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // 3-bit segment code: 0 is a pit, 1..5 are solid heights (higher code = taller ground)
   typedef logic [2:0] code_t;

   localparam code_t CODE_PIT = 3'd0;
   localparam code_t CODE_MIN = 3'd1;
   localparam code_t CODE_MAX = 3'd5;

   // Generator action selected by the two low LFSR bits
   typedef enum logic [1:0] {
      GEN_DOWN = 2'd0,
      GEN_UP   = 2'd1,
      GEN_FLAT = 2'd2,
      GEN_PIT  = 2'd3
   } gen_op_e;

   // Screen row of the ground surface for a segment code; a pit sits below the visible area
   function automatic logic [9:0] code_height(code_t c);
      if (c == CODE_PIT) begin
         return 10'(PIT_Y);
      end
      return 10'(448 - 24 * int'(c));
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, right-shifting form:
// the feedback of bits 0,2,3,5 enters at bit 15. Steps only when advance is high.
module lfsr16
   import terrain_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        advance,
   output logic [15:0] value
);

   logic [15:0] value_q;
   logic [15:0] value_d;
   logic        feedback;

   // Next LFSR value: shift once when asked, otherwise hold
   always_comb begin
      feedback = value_q[0] ^ value_q[2] ^ value_q[3] ^ value_q[5];
      value_d  = value_q;
      if (advance) begin
         value_d = {feedback, value_q[15:1]};
      end
   end

   // State register, reloaded with the seed on reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         value_q <= LFSR_SEED;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/terrain_gen.sv
// Side-scrolling terrain: a circular buffer of 16-px segment codes scrolled by
// speed pixels per frame, with new segments generated off-screen on the right.
// Provides the ground height under the stickman column and a per-pixel terrain flag.
module terrain_gen
   import terrain_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        enable,
   input  logic [2:0]  speed,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [9:0]  GroundY,
   output logic        is_ground,
   output logic [15:0] distance
);

   logic        frame_q,      frame_d;
   code_t       code_q [BUF_DEPTH];
   code_t       code_d [BUF_DEPTH];
   logic [5:0]  head_q,       head_d;
   logic [3:0]  offset_q,     offset_d;
   code_t       last_solid_q, last_solid_d;
   logic [1:0]  pit_run_q,    pit_run_d;
   logic [15:0] distance_q,   distance_d;
   logic [9:0]  ground_y_q,   ground_y_d;
   logic        is_ground_q,  is_ground_d;

   logic        frame_tick;
   logic [4:0]  offset_sum;
   logic        seg_adv;
   logic [15:0] lfsr_value;
   logic        lfsr_unused;
   gen_op_e     gen_op;
   code_t       gen_code;
   logic [5:0]  wr_idx;
   logic [5:0]  stick_idx;
   logic [5:0]  pix_idx;
   code_t       pix_code;
   logic [9:0]  pix_h;

   lfsr16 u_lfsr (
      .Clk     (Clk),
      .Reset   (Reset),
      .advance (seg_adv),
      .value   (lfsr_value)
   );

   // Only the two low bits pick the generator action; the rest are pure LFSR state
   assign lfsr_unused = ^lfsr_value[15:2];

   // Frame edge detect, scroll arithmetic and next-segment code selection
   always_comb begin
      frame_d    = frame_clk;
      frame_tick = frame_clk & ~frame_q;
      offset_sum = {1'b0, offset_q} + {2'b00, speed};
      // speed <= 7 keeps offset_sum below 32, so bit 4 alone flags a segment crossing
      seg_adv    = frame_tick & enable & offset_sum[4];
      gen_op     = gen_op_e'(lfsr_value[1:0]);
      wr_idx     = head_q + 6'(GEN_AHEAD);

      case (gen_op)
         GEN_DOWN: gen_code = (last_solid_q > CODE_MIN) ? last_solid_q - 3'd1 : CODE_MIN;
         GEN_UP:   gen_code = (last_solid_q < CODE_MAX) ? last_solid_q + 3'd1 : CODE_MAX;
         GEN_FLAT: gen_code = last_solid_q;
         default:  gen_code = (pit_run_q < 2'd2) ? CODE_PIT : last_solid_q;
      endcase
   end

   // Buffer write, head/offset advance and generator history on a segment crossing
   always_comb begin
      code_d       = code_q;
      head_d       = head_q;
      offset_d     = offset_q;
      last_solid_d = last_solid_q;
      pit_run_d    = pit_run_q;
      distance_d   = distance_q;

      if (frame_tick && enable) begin
         // Low four bits are offset_sum - 16 when crossing, offset_sum otherwise
         offset_d = offset_sum[3:0];
      end

      if (seg_adv) begin
         code_d[wr_idx] = gen_code;
         head_d         = head_q + 6'd1;
         if (gen_code == CODE_PIT) begin
            pit_run_d = pit_run_q + 2'd1;
         end else begin
            last_solid_d = gen_code;
            pit_run_d    = 2'd0;
         end
         if (distance_q != 16'hFFFF) begin
            distance_d = distance_q + 16'd1;
         end
      end
   end

   // Segment lookups for the stickman column and the current pixel
   always_comb begin
      stick_idx   = head_q + 6'((11'(STICK_X) + {7'b0, offset_q}) >> 4);
      pix_idx     = head_q + 6'(({1'b0, DrawX} + {7'b0, offset_q}) >> 4);
      pix_code    = code_q[pix_idx];
      pix_h       = code_height(pix_code);
      ground_y_d  = code_height(code_q[stick_idx]);
      is_ground_d = (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H)) &&
                    (pix_code != CODE_PIT) && (DrawY >= pix_h);
   end

   // State and output registers; reset wins over any coincident frame edge
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_q <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            code_q[i] <= CODE_MIN;
         end
         head_q       <= 6'd0;
         offset_q     <= 4'd0;
         last_solid_q <= CODE_MIN;
         pit_run_q    <= 2'd0;
         distance_q   <= 16'd0;
         ground_y_q   <= code_height(CODE_MIN);
         is_ground_q  <= 1'b0;
      end else begin
         frame_q      <= frame_d;
         code_q       <= code_d;
         head_q       <= head_d;
         offset_q     <= offset_d;
         last_solid_q <= last_solid_d;
         pit_run_q    <= pit_run_d;
         distance_q   <= distance_d;
         ground_y_q   <= ground_y_d;
         is_ground_q  <= is_ground_d;
      end
   end

   assign GroundY   = ground_y_q;
   assign is_ground = is_ground_q;
   assign distance  = distance_q;

endmodule

// File: tb/tb_terrain_gen.sv
// Randomized bench for terrain_gen with a behavioural terrain model stepped once per clock.
module tb_terrain_gen;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_clk;
   logic        enable;
   logic [2:0]  speed;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic [9:0]  GroundY;
   logic        is_ground;
   logic [15:0] distance;

   terrain_gen dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .enable    (enable),
      .speed     (speed),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .GroundY   (GroundY),
      .is_ground (is_ground),
      .distance  (distance)
   );

   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;

   // behavioural model state
   int m_code [64];
   int m_head, m_off, m_lfsr, m_last, m_pit, m_dist;
   bit m_prev;
   int e_gy;
   bit e_isg;
   bit [1:0] adv_hist;

   // observed-sequence tracker on the DUT's GroundY
   int pit_seen;
   bit have_solid;
   int last_gy;

   bit chk_en;
   bit rnd_pix;

   function automatic int hgt(int c);
      return (c == 0) ? 480 : 448 - 24 * c;
   endfunction

   function automatic int lookup(int x);
      return m_code[(m_head + (x + m_off) / 16) % 64];
   endfunction

   function automatic int lfsr_step(int v);
      int b;
      b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
      return (v >> 1) | (b << 15);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // predicts the effect of the coming rising edge from the inputs now applied
   task automatic model_step();
      int s, c, x, y;
      bit tick, adv;
      x   = int'(DrawX);
      y   = int'(DrawY);
      adv = 1'b0;
      e_gy  = hgt(lookup(160));
      c     = lookup(x);
      e_isg = (x < 640) && (y < 480) && (c != 0) && (y >= hgt(c));
      if (Reset) begin
         for (int i = 0; i < 64; i++) m_code[i] = 1;
         m_head = 0; m_off = 0; m_lfsr = 16'hACE1;
         m_last = 1; m_pit = 0; m_dist = 0; m_prev = 1'b0;
         e_gy = 424; e_isg = 1'b0;
      end else begin
         tick   = frame_clk && !m_prev;
         m_prev = frame_clk;
         if (tick && enable) begin
            s = m_off + int'(speed);
            if (s >= 16) begin
               case (m_lfsr % 4)
                  0: c = (m_last > 1) ? m_last - 1 : 1;
                  1: c = (m_last < 5) ? m_last + 1 : 5;
                  2: c = m_last;
                  default: c = (m_pit < 2) ? 0 : m_last;
               endcase
               if (c == 0) m_pit++;
               else begin m_last = c; m_pit = 0; end
               m_code[(m_head + 41) % 64] = c;
               m_head = (m_head + 1) % 64;
               m_off  = s - 16;
               m_lfsr = lfsr_step(m_lfsr);
               if (m_dist < 65535) m_dist++;
               adv = 1'b1;
            end else begin
               m_off = s;
            end
         end
      end
      adv_hist = {adv_hist[0], adv};
   endtask

   task automatic do_compare();
      int d;
      check("ground_y", GroundY, e_gy);
      check("is_ground", is_ground, e_isg);
      check("distance", distance, m_dist);
      if (adv_hist[1]) begin
         if (GroundY == 10'd480) begin
            pit_seen++;
            check("pit_run_le_2", pit_seen <= 2, 1);
         end else begin
            if (have_solid) begin
               d = int'(GroundY) - last_gy;
               if (d < 0) d = -d;
               check("solid_step_le_1", d <= 24, 1);
            end
            have_solid = 1'b1;
            last_gy    = int'(GroundY);
            pit_seen   = 0;
         end
      end
   endtask

   task automatic cyc();
      model_step();
      @(negedge Clk);
      if (chk_en) do_compare();
      if (rnd_pix) begin
         DrawX = 10'($urandom_range(0, 720));
         DrawY = 10'($urandom_range(300, 500));
      end
   endtask

   task automatic clear_tracker();
      pit_seen   = 0;
      have_solid = 1'b0;
      last_gy    = 0;
   endtask

   task automatic do_reset();
      Reset     = 1'b1;
      frame_clk = 1'b0;
      cyc();
      Reset = 1'b0;
      clear_tracker();
   endtask

   task automatic frame_edge(int hi, int lo);
      frame_clk = 1'b1;
      repeat (hi) cyc();
      frame_clk = 1'b0;
      repeat (lo) cyc();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: run did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int px, sx, h;
      Reset = 1'b1; frame_clk = 1'b0; enable = 1'b0; speed = 3'd0;
      DrawX = 10'd0; DrawY = 10'd0;
      chk_en = 1'b0; rnd_pix = 1'b0; adv_hist = 2'b00;
      clear_tracker();
      cyc();
      chk_en = 1'b1;

      // reset state and all-ones buffer seen through pixels
      do_reset();
      check("rst_ground_y", GroundY, 424);
      check("rst_is_ground", is_ground, 0);
      check("rst_distance", distance, 0);
      DrawX = 10'd0; DrawY = 10'd424; cyc();
      check("rst_code1_at_424", is_ground, 1);
      DrawY = 10'd423; cyc();
      check("rst_code1_at_423", is_ground, 0);

      // speed 4: four edges cross one segment, fifth leaves offset 4
      enable = 1'b1; speed = 3'd4;
      repeat (4) frame_edge(1, 1);
      check("spd4_dist_after_4", distance, 1);
      check("spd4_gy_after_4", GroundY, 424);
      frame_edge(1, 1);
      check("spd4_dist_after_5", distance, 1);
      // fresh seed 0xACE1 -> r=1 -> first code 2 (height 400) at buffer slot 41
      DrawX = 10'd636; DrawY = 10'd400; cyc();
      check("first_code_h400", is_ground, 1);
      DrawY = 10'd399; cyc();
      check("first_code_h399", is_ground, 0);
      DrawX = 10'd635; DrawY = 10'd400; cyc();
      check("offset4_seg40", is_ground, 0);

      // long high frame strobe, then speed 0 and enable 0 hold everything
      do_reset();
      rnd_pix = 1'b1; enable = 1'b1; speed = 3'd7;
      frame_edge(1000, 1);
      check("hold_high_dist", distance, 0);
      frame_edge(1, 1);
      frame_edge(1, 1);
      check("hold_then_two_dist", distance, 1);
      speed = 3'd0;
      repeat (10) frame_edge(2, 2);
      check("spd0_dist", distance, 1);
      check("spd0_gy", GroundY, 424);
      speed = 3'd7; enable = 1'b0;
      repeat (10) frame_edge(2, 2);
      check("en0_dist", distance, 1);
      check("en0_gy", GroundY, 424);
      enable = 1'b1;
      frame_edge(1, 1);
      check("resume_off12_dist", distance, 1);
      frame_edge(1, 1);
      check("resume_cross_dist", distance, 2);

      // 10000 segments at full speed
      do_reset();
      speed = 3'd7; enable = 1'b1;
      for (int i = 0; i < 30000 && m_dist < 10000; i++) frame_edge(1, 1);
      check("long_run_dist", distance, 10000);

      // randomized speeds, enables and strobe shapes
      for (int i = 0; i < 1500; i++) begin
         speed  = 3'($urandom_range(0, 7));
         enable = ($urandom_range(0, 9) != 0);
         frame_edge($urandom_range(1, 3), $urandom_range(1, 3));
      end

      // directed pixel boundaries on the current terrain
      rnd_pix = 1'b0;
      DrawX = 10'd700; DrawY = 10'd450; cyc();
      check("offscreen_x700", is_ground, 0);
      DrawX = 10'd100; DrawY = 10'd500; cyc();
      check("offscreen_y500", is_ground, 0);
      px = -1; sx = -1;
      for (int x = 0; x < 640; x++) begin
         if (px < 0 && lookup(x) == 0) px = x;
         if (sx < 0 && lookup(x) != 0) sx = x;
      end
      if (px >= 0) begin
         DrawX = 10'(px); DrawY = 10'd479; cyc();
         check("pit_y479", is_ground, 0);
      end
      if (sx >= 0) begin
         h = hgt(lookup(sx));
         DrawX = 10'(sx); DrawY = 10'(h - 1); cyc();
         check("solid_h_minus_1", is_ground, 0);
         DrawY = 10'(h); cyc();
         check("solid_h", is_ground, 1);
      end

      // reset mid-scroll (offset 12, distance 37) coincident with a frame edge
      do_reset();
      speed = 3'd4; enable = 1'b1;
      repeat (151) frame_edge(1, 1);
      check("pre_reset_dist", distance, 37);
      DrawX = 10'd0; DrawY = 10'd424;
      Reset = 1'b1; frame_clk = 1'b1; cyc();
      check("midrst_gy", GroundY, 424);
      check("midrst_is_ground", is_ground, 0);
      check("midrst_dist", distance, 0);
      Reset = 1'b0; frame_clk = 1'b0; clear_tracker(); cyc();
      check("midrst_codes_1", is_ground, 1);
      check("midrst_no_tick", distance, 0);
      repeat (5) frame_edge(1, 1);
      check("restart_dist", distance, 1);
      DrawX = 10'd636; DrawY = 10'd400; cyc();
      check("restart_first_code_h400", is_ground, 1);
      DrawY = 10'd399; cyc();
      check("restart_first_code_h399", is_ground, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
